// File: rtl/pipe_hazard_ctrl_if.sv
// Control bundle between the 5-stage pipeline and its hazard sequencer.
// HAZ_PERF_CNT_EN adds the stall/flush performance counters (and CNT_W).
interface pipe_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5
`ifdef HAZ_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
);
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic [REG_ADDR_W-1:0] ex_rt;
  logic                  id_uses_rt;
  logic                  id_is_md;
  logic                  ex_memread;
  logic                  ex_br_taken;
  logic                  md_done;
  logic                  pc_write;
  logic                  ifid_write;
  logic                  ifid_flush;
  logic                  idex_bubble;
  logic                  md_start;
  logic                  md_timeout;
`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  modport master (
    output id_rs, id_rt, ex_rt, id_uses_rt, id_is_md, ex_memread, ex_br_taken, md_done,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, md_start, md_timeout,
           stall_cnt, flush_cnt
  );
  modport slave (
    input  id_rs, id_rt, ex_rt, id_uses_rt, id_is_md, ex_memread, ex_br_taken, md_done,
    output pc_write, ifid_write, ifid_flush, idex_bubble, md_start, md_timeout,
           stall_cnt, flush_cnt
  );
`else
  modport master (
    output id_rs, id_rt, ex_rt, id_uses_rt, id_is_md, ex_memread, ex_br_taken, md_done,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, md_start, md_timeout
  );
  modport slave (
    input  id_rs, id_rt, ex_rt, id_uses_rt, id_is_md, ex_memread, ex_br_taken, md_done,
    output pc_write, ifid_write, ifid_flush, idex_bubble, md_start, md_timeout
  );
`endif
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer: load-use stall, taken-branch squash, mul/div start/wait/release.
// HAZ_PERF_CNT_EN adds saturating stall/flush cycle counters (width CNT_W).
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MD_TIMEOUT = 64
`ifdef HAZ_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave hz
);
  localparam int WCNT_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MD_TIMEOUT - 1);

  typedef enum logic [1:0] {RUN, MD_START, MD_WAIT, MD_RELEASE} state_e;

  state_e              state_q, state_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                md_timeout_q, md_timeout_d;
  logic [REG_ADDR_W-1:0] id_rs, id_rt, ex_rt;
  logic                lu;
  logic                pc_write, ifid_write, ifid_flush, idex_bubble, md_start;

  assign id_rs = hz.id_rs;
  assign id_rt = hz.id_rt;
  assign ex_rt = hz.ex_rt;
  // r0 is hardwired zero, so a load into it never creates a dependency
  assign lu = hz.ex_memread && (ex_rt != '0) &&
              ((ex_rt == id_rs) || (hz.id_uses_rt && (ex_rt == id_rt)));

  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    md_timeout_d = md_timeout_q;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    md_start     = 1'b0;
    unique case (state_q)
      RUN: begin
        if (hz.ex_br_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (lu) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end else if (hz.id_is_md) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          state_d     = MD_START;
        end
      end
      MD_START: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        md_start    = 1'b1;
        state_d     = MD_WAIT;
      end
      MD_WAIT: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        wcnt_d      = wcnt_q + WCNT_W'(1);
        if (hz.md_done) begin
          state_d = MD_RELEASE;
          wcnt_d  = '0;
        end else if ((MD_TIMEOUT != 0) && (wcnt_q == WCNT_LAST)) begin
          state_d      = MD_RELEASE;
          wcnt_d       = '0;
          md_timeout_d = 1'b1;
        end
      end
      MD_RELEASE: begin
        // the mul/div instr moves to EX now; id_is_md still high must not relaunch
        wcnt_d  = '0;
        state_d = RUN;
      end
    endcase
    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      md_start    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      wcnt_q       <= '0;
      md_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      md_timeout_q <= md_timeout_d;
    end
  end

  assign hz.pc_write    = pc_write;
  assign hz.ifid_write  = ifid_write;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_bubble = idex_bubble;
  assign hz.md_start    = md_start;
  assign hz.md_timeout  = md_timeout_q;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (ifid_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench: two controllers (mul/div timeout 64 and 4) driven with the same stimulus,
// checked every cycle against an operation-level reference model plus literal checks.
module tb_pipe_hazard_ctrl;
`ifdef HAZ_PERF_CNT_EN
  localparam int PCW = 2;
`endif

  typedef struct {
    logic       rst;
    logic [4:0] rs, rt, ex_rt;
    logic       uses_rt, is_md, memread, br, done;
  } in_t;

  // phase: -1 idle, 0 launch cycle, n>=1 n-th wait cycle, -2 release cycle
  typedef struct {
    int phase;
    bit to;
    int stall_n;
    int flush_n;
  } mdl_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t  cur;
  mdl_t m0, m1;
  int   errors = 0, checks = 0;
  logic [5:0] e0, e1;

`ifdef HAZ_PERF_CNT_EN
  pipe_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(PCW)) h0();
`else
  pipe_hazard_ctrl_if #(.REG_ADDR_W(5)) h0();
`endif
  pipe_hazard_ctrl_if #(.REG_ADDR_W(5)) h1();

  assign h0.id_rs = cur.rs;        assign h1.id_rs = cur.rs;
  assign h0.id_rt = cur.rt;        assign h1.id_rt = cur.rt;
  assign h0.ex_rt = cur.ex_rt;     assign h1.ex_rt = cur.ex_rt;
  assign h0.id_uses_rt = cur.uses_rt; assign h1.id_uses_rt = cur.uses_rt;
  assign h0.id_is_md = cur.is_md;  assign h1.id_is_md = cur.is_md;
  assign h0.ex_memread = cur.memread; assign h1.ex_memread = cur.memread;
  assign h0.ex_br_taken = cur.br;  assign h1.ex_br_taken = cur.br;
  assign h0.md_done = cur.done;    assign h1.md_done = cur.done;

`ifdef HAZ_PERF_CNT_EN
  pipe_hazard_ctrl #(.REG_ADDR_W(5), .MD_TIMEOUT(64), .CNT_W(PCW)) dut0 (.clk(clk), .reset(cur.rst), .hz(h0));
`else
  pipe_hazard_ctrl #(.REG_ADDR_W(5), .MD_TIMEOUT(64)) dut0 (.clk(clk), .reset(cur.rst), .hz(h0));
`endif
  pipe_hazard_ctrl #(.REG_ADDR_W(5), .MD_TIMEOUT(4)) dut1 (.clk(clk), .reset(cur.rst), .hz(h1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {pc_write, ifid_write, ifid_flush, idex_bubble, md_start, md_timeout}
  // for this cycle and advances the model across the coming clock edge.
  function automatic logic [5:0] mdl_eval(input in_t i, input int tmo, input int cmax,
                                           inout mdl_t m);
    logic [5:0] e;
    bit lu;
    int nph;
    lu = i.memread && (i.ex_rt != 0) &&
         ((i.ex_rt == i.rs) || (i.uses_rt && (i.ex_rt == i.rt)));
    nph = m.phase;
    if (i.rst) begin
      e = {5'b00110, m.to};
      m.phase = -1; m.to = 0; m.stall_n = 0; m.flush_n = 0;
      return e;
    end
    if (m.phase == -1) begin
      if (i.br)         e = {5'b11110, m.to};
      else if (lu)      e = {5'b00010, m.to};
      else if (i.is_md) begin e = {5'b00010, m.to}; nph = 0; end
      else              e = {5'b11000, m.to};
    end else if (m.phase == 0) begin
      e = {5'b00011, m.to}; nph = 1;
    end else if (m.phase == -2) begin
      e = {5'b11000, m.to}; nph = -1;
    end else begin
      e = {5'b00010, m.to};
      if (i.done) nph = -2;
      else if (tmo != 0 && m.phase == tmo) begin nph = -2; m.to = 1; end
      else nph = m.phase + 1;
    end
    if (!e[5] && m.stall_n < cmax) m.stall_n++;
    if (e[3] && m.flush_n < cmax) m.flush_n++;
    m.phase = nph;
    return e;
  endfunction

  // Single compare process: every cycle, both DUTs against the model
  always @(negedge clk) begin
`ifdef HAZ_PERF_CNT_EN
    chk("stall_cnt", 32'(h0.stall_cnt), 32'(m0.stall_n));
    chk("flush_cnt", 32'(h0.flush_cnt), 32'(m0.flush_n));
`endif
`ifdef HAZ_PERF_CNT_EN
    e0 = mdl_eval(cur, 64, (1 << PCW) - 1, m0);
`else
    e0 = mdl_eval(cur, 64, 1000000, m0);
`endif
    e1 = mdl_eval(cur, 4, 1000000, m1);
    chk("model_dut0", 32'({h0.pc_write, h0.ifid_write, h0.ifid_flush, h0.idex_bubble,
                          h0.md_start, h0.md_timeout}), 32'(e0));
    chk("model_dut1", 32'({h1.pc_write, h1.ifid_write, h1.ifid_flush, h1.idex_bubble,
                          h1.md_start, h1.md_timeout}), 32'(e1));
  end

  task automatic set_in(input bit rst, input int rs, input int rt, input bit urt,
                        input bit md, input bit mr, input int exrt, input bit br,
                        input bit dn);
    cur.rst = rst; cur.rs = 5'(rs); cur.rt = 5'(rt); cur.uses_rt = urt;
    cur.is_md = md; cur.memread = mr; cur.ex_rt = 5'(exrt); cur.br = br; cur.done = dn;
  endtask

  // new inputs just after the edge, literal checks 2 time units later
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int stalls, starts;

  initial begin
    m0 = '{phase: -1, to: 0, stall_n: 0, flush_n: 0};
    m1 = m0;
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("rst_pc_write", 32'(h0.pc_write), 0);
    chk("rst_flush", 32'(h0.ifid_flush), 1);
    chk("rst_bubble", 32'(h0.idex_bubble), 1);
    cyc(); cyc();
    #2 chk("rst_md_timeout", 32'(h0.md_timeout), 0);

    cyc(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 chk("idle_pc_write", 32'(h0.pc_write), 1);
    chk("idle_bubble", 32'(h0.idex_bubble), 0);

    cyc(); set_in(0, 8, 3, 0, 0, 1, 8, 0, 0);
    #2 chk("lu_pc_write", 32'(h0.pc_write), 0);
    chk("lu_ifid_write", 32'(h0.ifid_write), 0);
    chk("lu_bubble", 32'(h0.idex_bubble), 1);
    cyc(); set_in(0, 8, 3, 0, 0, 0, 8, 0, 0);
    #2 chk("lu_after_pc_write", 32'(h0.pc_write), 1);
    cyc(); set_in(0, 0, 3, 0, 0, 1, 0, 0, 0);
    #2 chk("lu_r0_pc_write", 32'(h0.pc_write), 1);
    chk("lu_r0_bubble", 32'(h0.idex_bubble), 0);

    cyc(); set_in(0, 8, 3, 0, 1, 1, 8, 1, 0);
    #2 chk("br_flush", 32'(h0.ifid_flush), 1);
    chk("br_bubble", 32'(h0.idex_bubble), 1);
    chk("br_pc_write", 32'(h0.pc_write), 1);
    chk("br_md_start", 32'(h0.md_start), 0);
    cyc(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 chk("br_next_md_start", 32'(h0.md_start), 0);
    chk("br_next_pc_write", 32'(h0.pc_write), 1);

    // mul/div: detect, launch, 5 waits with done on the 5th
    stalls = 0; starts = 0;
    for (int k = 0; k < 7; k++) begin
      cyc(); set_in(0, 0, 0, 0, 1, 0, 0, 0, k == 6);
      #2;
      if (!h0.pc_write) stalls++;
      if (h0.md_start) starts++;
    end
    chk("md_stalls", 32'(stalls), 7);
    chk("md_starts", 32'(starts), 1);
    cyc(); set_in(0, 0, 0, 0, 1, 0, 0, 0, 0);
    #2 chk("md_rel_pc_write", 32'(h0.pc_write), 1);
    chk("md_rel_bubble", 32'(h0.idex_bubble), 0);
    chk("md_rel_md_start", 32'(h0.md_start), 0);
`ifdef HAZ_PERF_CNT_EN
    chk("stall_cnt_sat", 32'(h0.stall_cnt), 3);
`endif
    cyc(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 chk("md_run_pc_write", 32'(h0.pc_write), 1);
    chk("md_run_md_start", 32'(h0.md_start), 0);

    // timeout on dut1 (limit 4): detect, launch, 4 waits, release
    cyc(); set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      cyc(); set_in(0, 0, 0, 0, 1, 0, 0, 0, 0);
      #2 chk("to_stall", 32'(h1.pc_write), 0);
    end
    chk("to_before", 32'(h1.md_timeout), 0);
    cyc(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 chk("to_rel_pc_write", 32'(h1.pc_write), 1);
    chk("to_rel_bubble", 32'(h1.idex_bubble), 0);
    chk("to_sticky", 32'(h1.md_timeout), 1);
    repeat (3) cyc();
    #2 chk("to_sticky_later", 32'(h1.md_timeout), 1);
    chk("dut0_still_waiting", 32'(h0.pc_write), 0);

    // reset while dut0 sits in the wait phase
    cyc(); set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 chk("midrst_pc_write", 32'(h0.pc_write), 0);
    chk("midrst_flush", 32'(h0.ifid_flush), 1);
    chk("midrst_md_start", 32'(h0.md_start), 0);
    cyc(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 chk("postrst_pc_write", 32'(h0.pc_write), 1);
    chk("postrst_md_start", 32'(h0.md_start), 0);
    chk("postrst_timeout_clr", 32'(h1.md_timeout), 0);

    // random traffic with small register space to make hazards common
    for (int n = 0; n < 4000; n++) begin
      cyc();
      set_in($urandom_range(99) < 2, $urandom_range(3), $urandom_range(3),
             $urandom_range(1), $urandom_range(9) < 2, $urandom_range(9) < 3,
             $urandom_range(3), $urandom_range(9) < 1, $urandom_range(99) < 8);
    end
    cyc();
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
